// File: rtl/mem_access_unit.sv
// Memory access unit: runs word/byte loads and stores against a word-wide,
// single-port, synchronous-read RAM. Byte stores are read-modify-write.
// Load results are sign/zero extended and held until the next successful load.
module mem_access_unit #(
   parameter int unsigned ADDR_W     = 10,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              mem_write_i,
   input  logic [1:0]        mem_mode_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              ready_o,
   output logic              err_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   localparam logic [1:0] ModeWord  = 2'b00;
   localparam logic [1:0] ModeSByte = 2'b01;
   localparam logic [1:0] ModeUByte = 2'b10;
   localparam logic [1:0] ModeRsvd  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StLoadCap,
      StMerge,
      StWrite,
      StDone
   } state_e;

   state_e             state_q;
   logic [ADDR_W+1:0]  addr_q;
   logic [1:0]         mode_q;
   logic [31:0]        wdata_q;
   logic               write_q;
   logic               err_q;
   logic [31:0]        wbuf_q;
   logic [31:0]        rdata_q;

   logic [4:0]         lane_sh;
   logic [7:0]         lane_byte;
   logic [31:0]        load_d;
   logic [31:0]        wbuf_d;
   logic               bad_req;
   logic               unused_addr;

   // Address bits above the RAM range alias onto the same words.
   assign unused_addr = ^addr_i[31:ADDR_W+2];

   // Decode of an incoming request that can never touch the RAM.
   assign bad_req = (mem_mode_i == ModeRsvd) ||
                    ((mem_mode_i == ModeWord) && (addr_i[1:0] != 2'b00));

   // Byte-lane selection, load extension and store merge on the RAM read word.
   always_comb begin
      // Big-endian: offset 0 is the top byte, so the shift is (3 - offset) bytes.
      lane_sh   = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
      lane_byte = 8'(ram_rdata_i >> lane_sh);
      load_d    = ram_rdata_i;
      unique case (mode_q)
         ModeSByte: load_d = {{24{lane_byte[7]}}, lane_byte};
         ModeUByte: load_d = {24'h000000, lane_byte};
         default:   load_d = ram_rdata_i;
      endcase
      wbuf_d = (ram_rdata_i & ~(32'h0000_00ff << lane_sh)) |
               ({24'h000000, wdata_q[7:0]} << lane_sh);
   end

   // Access sequencer with the latched request and data registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         mode_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_i) begin
                  addr_q  <= addr_i[ADDR_W+1:0];
                  mode_q  <= mem_mode_i;
                  wdata_q <= wdata_i;
                  write_q <= mem_write_i;
                  if (bad_req) begin
                     err_q   <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= (mem_write_i && (mem_mode_i == ModeWord)) ? StWrite : StRd;
                  end
               end
            end
            StRd: begin
               state_q <= write_q ? StMerge : StLoadCap;
            end
            StLoadCap: begin
               rdata_q <= load_d;
               state_q <= StDone;
            end
            StMerge: begin
               wbuf_q  <= wbuf_d;
               state_q <= StWrite;
            end
            StWrite: begin
               state_q <= StDone;
            end
            StDone: begin
               // req is deliberately ignored here; a held req restarts from IDLE.
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // RAM strobes decoded from state so an asynchronous reset drops them at once.
   always_comb begin
      ram_en_o    = (state_q == StRd);
      ram_we_o    = (state_q == StWrite);
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if ((state_q == StRd) || (state_q == StWrite)) begin
         ram_addr_o = addr_q[ADDR_W+1:2];
      end
      if (state_q == StWrite) begin
         ram_wdata_o = (mode_q == ModeWord) ? wdata_q : wbuf_q;
      end
      ready_o = (state_q == StDone);
      err_o   = (state_q == StDone) && err_q;
      rdata_o = rdata_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed memory model plus per-cycle compare.
module tb_mem_access_unit;

   localparam int unsigned AW = 10;
   localparam bit          BE = 1'b1;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b1;
   logic          req_i       = 1'b0;
   logic          mem_write_i = 1'b0;
   logic [1:0]    mem_mode_i  = 2'b00;
   logic [31:0]   addr_i      = '0;
   logic [31:0]   wdata_i     = '0;
   logic [31:0]   rdata_o;
   logic          ready_o;
   logic          err_o;
   logic          ram_en_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic [31:0]   ram_rdata   = '0;

   mem_access_unit #(
      .ADDR_W     (AW),
      .BIG_ENDIAN (BE)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .mem_write_i (mem_write_i),
      .mem_mode_i  (mem_mode_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .ready_o     (ready_o),
      .err_o       (err_o),
      .ram_en_o    (ram_en_o),
      .ram_we_o    (ram_we_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Synchronous-read RAM seen by the DUT, with a bench-side preload port.
   logic [31:0]   ram [1024];
   logic          pl_en   = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = '0;
   always @(posedge clk_i) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else begin
         if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
         if (ram_en_o) ram_rdata <= ram[ram_addr_o];
      end
   end

   // Reference model: flat byte memory and the current transaction's expectations.
   logic [7:0]    mb [4096];
   logic          t_valid = 1'b0;
   logic          t_load  = 1'b0;
   logic          t_store = 1'b0;
   logic          t_byte  = 1'b0;
   logic          t_err   = 1'b0;
   int            t_start = 0;
   int            t_lat   = 0;
   logic [31:0]   t_res   = '0;
   logic [31:0]   t_wword = '0;
   logic [AW-1:0] t_wa    = '0;
   logic [31:0]   exp_rdata = '0;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mword(input int wa);
      int base;
      base = wa * 4;
      if (BE) return {mb[base], mb[base+1], mb[base+2], mb[base+3]};
      else    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
   endfunction

   // Per-cycle compare against the latency/behaviour rules of the model.
   int   cn;
   logic e_rdy, e_we, e_en;
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_rdata = '0;
      end else begin
         cn    = cyc - t_start;
         e_rdy = t_valid && (cn == t_lat);
         e_we  = t_valid && t_store && !t_err && (cn == t_lat - 1);
         e_en  = t_valid && !t_err && (t_load || t_byte) && (cn == 1);
         if (e_rdy && t_load && !t_err) exp_rdata = t_res;
         chk("ready", {31'b0, ready_o}, {31'b0, e_rdy});
         chk("err", {31'b0, err_o}, {31'b0, e_rdy && t_err});
         chk("rdata", rdata_o, exp_rdata);
         chk("ram_en", {31'b0, ram_en_o}, {31'b0, e_en});
         chk("ram_we", {31'b0, ram_we_o}, {31'b0, e_we});
         if (e_we) chk("ram_wdata", ram_wdata_o, t_wword);
         if (e_we || e_en) chk("ram_addr", {22'b0, ram_addr_o}, {22'b0, t_wa});
      end
   end

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      int base;
      base    = int'(a[11:2]) * 4;
      pl_en   = 1'b1;
      pl_addr = a[11:2];
      pl_data = v;
      for (int i = 0; i < 4; i++) mb[base+i] = BE ? v[31-8*i -: 8] : v[8*i +: 8];
      @(posedge clk_i);
      #2;
      pl_en = 1'b0;
   endtask

   // Issue one access (called at posedge+2 with the DUT idle) and wait for ready.
   task automatic access(input logic w, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] d);
      int   a12, wa, base;
      logic e, got;
      logic [7:0] b;
      a12 = int'(a[11:0]);
      wa  = a12 / 4;
      base = wa * 4;
      e   = (m == 2'b11) || ((m == 2'b00) && (a[1:0] != 2'b00));
      b   = mb[a12];
      t_res = '0;
      t_wword = '0;
      if (e) begin
         t_lat = 1;
      end else if (w) begin
         if (m == 2'b00) begin
            t_lat = 2;
            for (int i = 0; i < 4; i++) mb[base+i] = BE ? d[31-8*i -: 8] : d[8*i +: 8];
         end else begin
            t_lat = 4;
            mb[a12] = d[7:0];
         end
         t_wword = mword(wa);
      end else begin
         t_lat = 3;
         if (m == 2'b00)      t_res = mword(wa);
         else if (m == 2'b01) t_res = {{24{b[7]}}, b};
         else                 t_res = {24'h0, b};
      end
      t_load  = !w;
      t_store = w;
      t_byte  = w && (m != 2'b00);
      t_err   = e;
      t_wa    = a[11:2];
      t_start = cyc;
      t_valid = 1'b1;
      req_i = 1'b1; mem_write_i = w; mem_mode_i = m; addr_i = a; wdata_i = d;
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge clk_i);
         #1;
         if (ready_o) got = 1'b1;
      end
      chk("ready_seen", {31'b0, got}, 32'd1);
      @(posedge clk_i);
      #2;
      req_i = 1'b0;
      mem_write_i = 1'b0;
      if (!e) chk("ram_word", ram[wa], mword(wa));
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic quiet_bad;
   initial begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
      #1 rst_ni = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_ready", {31'b0, ready_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      chk("rst_ram_en", {31'b0, ram_en_o}, 32'h0);
      chk("rst_ram_we", {31'b0, ram_we_o}, 32'h0);
      chk("rst_ram_addr", {22'b0, ram_addr_o}, 32'h0);
      chk("rst_ram_wdata", ram_wdata_o, 32'h0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #2;

      // Unsigned byte loads, big-endian lanes.
      preload(32'h10, 32'h11223344);
      access(1'b0, 2'b10, 32'h10, 32'h0);
      chk("tp1_ub0", rdata_o, 32'h00000011);
      access(1'b0, 2'b10, 32'h13, 32'h0);
      chk("tp1_ub3", rdata_o, 32'h00000044);

      // Sign versus zero extension.
      preload(32'h20, 32'h80FF7F01);
      access(1'b0, 2'b01, 32'h20, 32'h0);
      chk("tp2_sb0", rdata_o, 32'hFFFFFF80);
      access(1'b0, 2'b10, 32'h20, 32'h0);
      chk("tp2_ub0", rdata_o, 32'h00000080);
      access(1'b0, 2'b01, 32'h22, 32'h0);
      chk("tp2_sb2", rdata_o, 32'h0000007F);
      access(1'b0, 2'b01, 32'h21, 32'h0);
      chk("tp2_sb1", rdata_o, 32'hFFFFFFFF);

      // Byte store read-modify-write, then word readback.
      access(1'b1, 2'b01, 32'h12, 32'h000000AB);
      chk("tp3_ram", ram[4], 32'h1122AB44);
      chk("tp3_rdata_kept", rdata_o, 32'hFFFFFFFF);
      access(1'b0, 2'b00, 32'h10, 32'h0);
      chk("tp3_word", rdata_o, 32'h1122AB44);

      // Word store at the top word and an aliased readback.
      access(1'b1, 2'b00, 32'h3FC, 32'hDEADBEEF);
      chk("tp4_ram", ram[255], 32'hDEADBEEF);
      access(1'b0, 2'b00, 32'h13FC, 32'h0);
      chk("tp4_alias", rdata_o, 32'hDEADBEEF);

      // Error cases leave RAM and rdata alone.
      access(1'b0, 2'b00, 32'h06, 32'h0);
      access(1'b0, 2'b11, 32'h10, 32'h0);
      access(1'b1, 2'b11, 32'h10, 32'h55);
      access(1'b1, 2'b00, 32'h12, 32'h12345678);
      chk("tp5_rdata_hold", rdata_o, 32'hDEADBEEF);
      chk("tp5_ram_hold", ram[4], 32'h1122AB44);

      // Reset during MERGE aborts a byte store.
      preload(32'h10, 32'h11223344);
      t_lat = 4; t_load = 1'b0; t_store = 1'b1; t_byte = 1'b1; t_err = 1'b0;
      t_wa = 10'h4; t_start = cyc; t_valid = 1'b1;
      req_i = 1'b1; mem_write_i = 1'b1; mem_mode_i = 2'b10; addr_i = 32'h12; wdata_i = 32'hCD;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      t_valid = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("tp6_we", {31'b0, ram_we_o}, 32'h0);
      chk("tp6_en", {31'b0, ram_en_o}, 32'h0);
      chk("tp6_ready", {31'b0, ready_o}, 32'h0);
      chk("tp6_rdata", rdata_o, 32'h0);
      chk("tp6_addr", {22'b0, ram_addr_o}, 32'h0);
      chk("tp6_wdata", ram_wdata_o, 32'h0);
      req_i = 1'b0;
      mem_write_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      quiet_bad = 1'b0;
      repeat (6) begin
         @(negedge clk_i);
         #1;
         if (ready_o || ram_we_o) quiet_bad = 1'b1;
      end
      chk("tp6_quiet", {31'b0, quiet_bad}, 32'h0);
      chk("tp6_ram", ram[4], 32'h11223344);
      @(posedge clk_i);
      #2;
      access(1'b0, 2'b00, 32'h10, 32'h0);
      chk("tp6_after", rdata_o, 32'h11223344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle controller/datapath and a word-wide, single-port, synchronous-read data RAM.
- Executes word and byte loads and stores requested by the controller's MemWrite/MemMode encoding.
- Byte stores are done as read-modify-write over the word-only RAM.
- Returns sign- or zero-extended load data and a one-cycle ready pulse, which the controller uses to stall its memory states.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth 2^ADDR_W words)
BIG_ENDIAN, 1, 1: byte offset 0 maps to bits[31:24]; 0: offset 0 maps to bits[7:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  access request; held with all request fields stable until ready
mem_write  input  1  1 = store, 0 = load
mem_mode  input  2  00 word, 01 signed byte, 10 unsigned byte, 11 reserved
addr  input  32  byte address
wdata  input  32  store data; byte stores use wdata[7:0]
rdata  output  32  extended load result, registered
ready  output  1  one-cycle completion pulse
err  output  1  valid with ready; misaligned word access or reserved mode
ram_en  output  1  RAM read enable; ram_rdata is valid the cycle after
ram_we  output  1  RAM write enable, one cycle
ram_addr  output  ADDR_W  word address, addr[ADDR_W+1:2]
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data

Behaviour:
- Reset value of every output is 0: rdata, ready, err, ram_en, ram_we, ram_addr, ram_wdata.
  - Reset forces the state machine to IDLE asynchronously and clears all latched request fields.
- State machine states: IDLE, RD, LOAD_CAP, MERGE, WRITE, DONE.
- IDLE:
  - On req=1, latch addr, mode, wdata and mem_write.
  - If mode=11, or mode=00 with addr[1:0]!=0, go to DONE with the err flag set.
  - Else if this is a word store, go to WRITE.
  - Else go to RD.
- RD:
  - ram_en=1 and ram_addr driven from the latched address.
  - Go to LOAD_CAP for a load, MERGE for a byte store.
- LOAD_CAP:
  - Capture ram_rdata and select the lane addressed by addr[1:0] under BIG_ENDIAN.
  - Mode 01 sign-extends bit 7 of the selected byte; mode 10 zero-extends; mode 00 passes the full word.
  - Register the result into rdata, then go to DONE.
- MERGE:
  - Replace the addressed byte lane of ram_rdata with wdata[7:0] and register it into the write buffer.
  - Go to WRITE.
- WRITE:
  - ram_we=1, ram_addr from the latched address.
  - ram_wdata is the write buffer (byte store) or the latched wdata (word store).
  - Go to DONE.
- DONE:
  - ready=1, and err=1 if flagged. Return to IDLE.
  - req is ignored in DONE; a request still high in the following IDLE cycle is treated as a new access.
- ram_en, ram_we, ram_addr and ram_wdata are decoded from the current state, so an asynchronous reset drops ram_we immediately. No write occurs unless reset is high across the WRITE clock edge.
- Latency from the IDLE cycle that samples req to the ready cycle:
  - word store: 2 cycles
  - load (any mode): 3 cycles
  - byte store: 4 cycles
  - error: 1 cycle
- rdata:
  - Holds its value until the next successful load's LOAD_CAP.
  - Stores and errors leave it unchanged; errors do not clear it.
- Errors never assert ram_en or ram_we.
- Address bits above ADDR_W+1 are ignored (wrap-around modulo RAM size).
- Reset while the block is in RD, LOAD_CAP, MERGE or WRITE aborts the access. No ready pulse is produced and RAM is unmodified, except for a WRITE edge that has already completed.

Test Plan:
1. RAM[0x10>>2]=0x11223344, BIG_ENDIAN=1, unsigned byte load at 0x10 then 0x13 -> rdata=0x00000011 then 0x00000044; each ready arrives 3 cycles after req.
2. RAM word=0x80FF7F01 at 0x20: signed byte load at 0x20 -> 0xFFFFFF80; unsigned at 0x20 -> 0x00000080; signed at 0x22 -> 0x0000007F.
3. RAM word 0x11223344 at 0x10, byte store wdata=0x000000AB at 0x12 -> one ram_we pulse with ram_wdata=0x1122AB44 and ready 4 cycles after req; a word load of 0x10 then returns 0x1122AB44.
4. Word store 0xDEADBEEF at 0x3FC (ADDR_W=10) -> ram_addr=0xFF, ram_we 1 cycle, ready 2 cycles after req; address 0x13FC aliases to the same word.
5. Word load at 0x06, and any req with mode=11 -> ready=1 and err=1 one cycle after req; ram_en and ram_we stay 0; rdata unchanged.
6. Byte store started, reset driven low during MERGE -> outputs go to 0 immediately, ram_we never asserts, target word still 0x11223344, and no ready pulse.
